// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (8N1) with framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_error strobe.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] tick_cnt;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          mid;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Ticks only run inside a frame so their phase is locked to the start edge.
    assign tick = (state != IDLE) && (tick_cnt == CW'(DIV - 1));
    assign mid  = tick && (samp_cnt == 4'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            samp_cnt <= 4'd0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= 4'd0;
        end else if (tick) begin
            tick_cnt <= '0;
            samp_cnt <= samp_cnt + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (mid) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    if (mid) begin
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error <= ^{shreg, par_bit};
`endif
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; directed cases then random frames.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT_NS = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         pe_cnt = 0;
    int         pe_alone_cnt = 0;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    bit         busy_seen = 1'b0;
    logic       prev_vld = 1'b0;
    logic       prev_fe = 1'b0;
    logic [7:0] last_good;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (100_000_000),
        .BAUD_RATE(6_250_000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    // Event recorder, sampled on the inactive edge.
    always @(negedge clk) begin
        if (data_valid) got_q.push_back(data_out);
        if (frame_error) fe_cnt++;
        if (data_valid && frame_error) overlap_cnt++;
        if ((data_valid && prev_vld) || (frame_error && prev_fe)) wide_cnt++;
        if (busy) busy_seen = 1'b1;
        prev_vld = data_valid;
        prev_fe  = frame_error;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_cnt++;
        if (parity_error && !data_valid) pe_alone_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; rx is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip, input int p);
        rx = 1'b0;
        #(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(p);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        #(p);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop;
        #(p);
    endtask

    task automatic clear_events();
        got_q.delete();
        fe_cnt    = 0;
        busy_seen = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_cnt = 0;
`endif
    endtask

    function automatic logic [7:0] first_got();
        return (got_q.size() > 0) ? got_q[0] : 8'hxx;
    endfunction

    initial begin
        logic [7:0] b;
        logic       stop;
        int         p;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame 0xAA
        clear_events();
        @(posedge clk); #3;
        send_frame(8'hAA, 1'b1, 1'b0, BIT_NS);
        #(2 * BIT_NS); @(negedge clk);
        check("t1_count", got_q.size(), 1);
        check("t1_byte", first_got(), 8'hAA);
        check("t1_data_out", data_out, 8'hAA);
        check("t1_fe", fe_cnt, 0);
        check("t1_busy", busy, 1'b0);

        // Back-to-back 0xAA, 0xCC
        clear_events();
        @(posedge clk); #3;
        send_frame(8'hAA, 1'b1, 1'b0, BIT_NS);
        send_frame(8'hCC, 1'b1, 1'b0, BIT_NS);
        #(2 * BIT_NS); @(negedge clk);
        check("t2_count", got_q.size(), 2);
        check("t2_byte0", first_got(), 8'hAA);
        check("t2_byte1", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hCC);
        check("t2_fe", fe_cnt, 0);
        last_good = 8'hCC;

        // 4-clock glitch is a false start
        clear_events();
        @(posedge clk); #3;
        rx = 1'b0;
        #40;
        rx = 1'b1;
        #(2 * BIT_NS); @(negedge clk);
        check("t3_busy_seen", busy_seen, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_count", got_q.size(), 0);
        check("t3_fe", fe_cnt, 0);

        // Framing error with break held low
        clear_events();
        @(posedge clk); #3;
        send_frame(8'h55, 1'b0, 1'b0, BIT_NS);
        #(3 * BIT_NS); @(negedge clk);
        check("t4_fe", fe_cnt, 1);
        check("t4_busy_held", busy, 1'b1);
        check("t4_count", got_q.size(), 0);
        check("t4_data_out_kept", data_out, last_good);
        rx = 1'b1;
        #100; @(negedge clk);
        check("t4_busy_released", busy, 1'b0);

        // Reset mid-frame during data bit 3 of 0xF0
        clear_events();
        @(posedge clk); #3;
        b  = 8'hF0;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[3];
        #(BIT_NS / 2);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_data_out", data_out, 8'h00);
        check("t5_rst_data_valid", data_valid, 1'b0);
        check("t5_rst_frame_error", frame_error, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #(2 * BIT_NS);
        clear_events();
        @(posedge clk); #3;
        send_frame(8'h3C, 1'b1, 1'b0, BIT_NS);
        #(2 * BIT_NS); @(negedge clk);
        check("t5_count", got_q.size(), 1);
        check("t5_byte", first_got(), 8'h3C);
        check("t5_data_out", data_out, 8'h3C);
        check("t5_fe", fe_cnt, 0);
        last_good = 8'h3C;

`ifdef UART_RX_PARITY_EN
        // Parity error strobes alongside data_valid; correct parity stays quiet
        clear_events();
        @(posedge clk); #3;
        send_frame(8'h07, 1'b1, 1'b1, BIT_NS);
        #(2 * BIT_NS); @(negedge clk);
        check("t6_bad_count", got_q.size(), 1);
        check("t6_bad_byte", first_got(), 8'h07);
        check("t6_bad_pe", pe_cnt, 1);
        clear_events();
        @(posedge clk); #3;
        send_frame(8'h07, 1'b1, 1'b0, BIT_NS);
        #(2 * BIT_NS); @(negedge clk);
        check("t6_good_count", got_q.size(), 1);
        check("t6_good_pe", pe_cnt, 0);
        last_good = 8'h07;
`endif

        // Random bytes, +-2.5% baud offset, occasional bad stop bit
        for (int n = 0; n < 20; n++) begin
            clear_events();
            b    = 8'($urandom);
            p    = $urandom_range(156, 164);
            stop = ($urandom_range(0, 4) != 0);
            @(posedge clk); #3;
            send_frame(b, stop, 1'b0, p);
            if (!stop) begin
                #(p);
                rx = 1'b1;
            end
            #(2 * p); @(negedge clk);
            if (stop) begin
                check("rnd_count", got_q.size(), 1);
                check("rnd_byte", first_got(), b);
                check("rnd_fe", fe_cnt, 0);
                last_good = b;
            end else begin
                check("rnd_err_count", got_q.size(), 0);
                check("rnd_err_fe", fe_cnt, 1);
                check("rnd_err_data_out", data_out, last_good);
            end
        end

        check("pulse_overlap", overlap_cnt, 0);
        check("pulse_width", wide_cnt, 0);
`ifdef UART_RX_PARITY_EN
        check("pe_without_valid", pe_alone_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of `uart_tx_top` on the same serial link. Samples the asynchronous `rx` line with 16x oversampling, deserialises 8N1 frames LSB-first, and presents each byte on a one-cycle `data_valid` strobe. Flags framing errors. Sits between the board RX pin and the byte-consuming logic in the system clock domain.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate in baud.
- Derived constant `DIV = CLK_FREQ / (BAUD_RATE*16)`, truncated; must be ≥ 1. This is the number of clocks per oversample tick.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `data_out`  out  8  last correctly framed byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` has been updated.
- `frame_error`  out  1  one-cycle pulse when a stop bit is sampled low.
- `busy`  out  1  high while a frame is being received.
- `parity_error`  out  1  one-cycle pulse on parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- **Synchroniser:** `rx` passes through 2 flops that reset to 1. All logic uses the synchronised value `rx_s`.
- **Tick generator:** a divide-by-`DIV` counter emits `tick` once per `DIV` clocks. It is held at 0 in IDLE and starts on the start edge, so ticks are phase-aligned to the frame.
- **Sample counter:** 4-bit, 0..15, advances on each `tick`. A bit is sampled when the counter reads 7 (mid-bit). It wraps 15→0 at each bit boundary.
- **States:**
  - **IDLE:** `busy`=0. A falling `rx_s` (1→0) moves to START.
  - **START:** at the mid-bit sample, `rx_s`=0 moves to DATA; `rx_s`=1 is a false start and returns to IDLE with no output pulse.
  - **DATA:** 8 mid-bit samples are shifted in LSB-first. A 3-bit index counts 0..7; index 7 moves to STOP (or PARITY when the macro is set).
  - **STOP:** at the mid-bit sample:
    - `rx_s`=1: load `data_out` from the shift register, pulse `data_valid`, go to IDLE.
    - `rx_s`=0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. A break condition produces no further pulses.
- `busy` is 1 in every state except IDLE.
- Return to IDLE at mid-stop allows a back-to-back start edge half a bit later to be caught.
- **Reset (any time, including mid-frame):**
  - State → IDLE; counters → 0; shift register → 0; partial byte discarded.
  - `data_out`=0x00; `data_valid`=0, `frame_error`=0, `busy`=0, `parity_error`=0.

## Timing
- All outputs are registered.
- Start-edge detect occurs 2 clocks after `rx` falls (synchroniser latency).
- `busy` rises 1 clock after edge detect.
- `data_valid`/`frame_error` assert on the clock after the stop-bit mid-sample tick: about 9.5 bit times plus 3 clocks after `rx` falls. With parity, add one bit time.
- Pulses are exactly 1 clock wide. Only one of `data_valid`/`frame_error` fires per frame.
- `data_out` is stable from the `data_valid` pulse until the next `data_valid`.
- Sampling tolerance: the receiver must decode correctly with ±3% baud mismatch.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - Frame is 8E1. A PARITY state follows DATA and samples one bit at mid-bit.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - On mismatch, `parity_error` pulses in the same cycle as `data_valid`; `data_out` is still updated.
  - A stop error takes precedence: `frame_error` only, no `parity_error`.
- **Undefined:**
  - Frame is 8N1. The `parity_error` port and PARITY state do not exist.

## Test plan
Bench settings: `CLK_FREQ`=100_000_000, `BAUD_RATE`=6_250_000 (`DIV`=1, 16 clocks/bit, 10 ns clock).
1. Single frame 0xAA, stop=1 → exactly one `data_valid` pulse, `data_out`=0xAA, `frame_error`=0, `busy` low afterwards.
2. Back-to-back frames 0xAA then 0xCC, each with a 1-bit stop → two `data_valid` pulses, `data_out`=0xAA then 0xCC, no errors.
3. `rx` low glitch of 4 clocks, then high → `busy` pulses briefly, then returns to IDLE; no `data_valid`, no `frame_error`.
4. Frame 0x55 with stop=0 and `rx` held low 3 more bits → one `frame_error` pulse, `data_out` keeps its prior value, `busy` stays 1 until `rx` rises.
5. `reset` asserted during data bit 3 of 0xF0, then released, then 0x3C sent → all outputs 0 during reset; next `data_valid` gives `data_out`=0x3C.
6. With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 (correct is 1) → `data_valid` and `parity_error` pulse in the same cycle, `data_out`=0x07. With parity bit 1 → `parity_error` stays 0.
